// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//
// Instruction fetch front end. Requests FETCH_WIDTH consecutive 32-bit words
// per memory transaction and keeps them, tagged with their PCs, in a circular
// queue. The issue logic pops the queue one entry per cycle. A redirect
// flushes the queue, restarts fetch at a new PC and discards any response
// that is still in flight.
//
// Handshakes:
//   imem_req_o/imem_gnt_i: the request (address in imem_addr_o) is presented
//     while imem_req_o is high. It is accepted in a cycle where both
//     imem_req_o and imem_gnt_i are high. Until then imem_req_o and
//     imem_addr_o do not change, unless a redirect withdraws the request.
//     At most one request is outstanding.
//   imem_rvalid_i: one-cycle response strobe for the outstanding request.
//     Memory cannot stall it, and it carries FETCH_WIDTH words.
//   iq_read_i: pops the head entry in any cycle where iq_empty_o is low.
//     A read while the queue is empty is ignored.
//
// Ports:
//   clk_i, reset_ni         clock, asynchronous active-low reset
//   imem_req_o/addr_o       fetch request and byte address of its first word
//   imem_gnt_i              request accepted this cycle
//   imem_rvalid_i/rdata_i   response strobe and words (word k at [32k+31:32k])
//   redirect_i/pc_i         flush and restart fetch at redirect_pc_i
//   iq_read_i               pop the head entry
//   iq_empty_o              queue holds no entries
//   iq_instr_o/iq_pc_o      head entry (0 while empty)
//   iq_count_o              number of valid entries
//   dbg_state_o             current fetch FSM state (IDLE/REQ/WAIT/DROP)
//
// Legal configurations: FETCH_WIDTH in {1,2,4}, and 2**QUEUE_POW2 >= 2*FETCH_WIDTH.

module fetch_queue_unit #(
    parameter int          FETCH_WIDTH = 2,
    parameter int          QUEUE_POW2  = 3,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    output logic                      imem_req_o,
    output logic [31:0]               imem_addr_o,
    input  logic                      imem_gnt_i,
    input  logic                      imem_rvalid_i,
    input  logic [32*FETCH_WIDTH-1:0] imem_rdata_i,
    input  logic                      redirect_i,
    input  logic [31:0]               redirect_pc_i,
    input  logic                      iq_read_i,
    output logic                      iq_empty_o,
    output logic [31:0]               iq_instr_o,
    output logic [31:0]               iq_pc_o,
    output logic [QUEUE_POW2:0]       iq_count_o,
    output logic [1:0]                dbg_state_o
);

    localparam int          DEPTH       = 1 << QUEUE_POW2;
    localparam int          PW          = QUEUE_POW2 + 1;
    localparam logic [PW-1:0] SPACE_LIMIT = PW'(DEPTH - FETCH_WIDTH);
    localparam logic [31:0] FETCH_BYTES = 32'(4 * FETCH_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic            started_q;

    logic [31:0]     instr_mem_q [DEPTH];
    logic [31:0]     pc_mem_q    [DEPTH];

    logic [PW-1:0]   count;
    logic            empty;
    logic            space_ok;
    logic            req_active;
    logic            wr_en;
    logic            pop;
    logic [QUEUE_POW2-1:0] head_idx;
    logic [QUEUE_POW2-1:0] tail_idx;

    assign count    = tail_q - head_q;
    assign empty    = (head_q == tail_q);
    assign head_idx = head_q[QUEUE_POW2-1:0];
    assign tail_idx = tail_q[QUEUE_POW2-1:0];

    // Room for a whole response is reserved when the request is raised. Pops
    // in the current cycle are deliberately not credited.
    assign space_ok = (count <= SPACE_LIMIT);

    // started_q holds the request low in the cycle when reset is released.
    // The request can then rise combinationally from IDLE as soon as space
    // appears. In REQ it is held regardless of count, because count can only
    // fall while a request is pending.
    assign req_active = started_q &&
                        ((state_q == S_REQ) || (state_q == S_IDLE && space_ok));

    assign wr_en = (state_q == S_WAIT) && imem_rvalid_i && !redirect_i;
    assign pop   = iq_read_i && !empty && !redirect_i;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;

        case (state_q)
            S_IDLE, S_REQ: begin
                if (req_active) begin
                    if (imem_gnt_i) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + FETCH_BYTES;
                        state_d    = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_WAIT: if (imem_rvalid_i) state_d = S_IDLE;
            S_DROP: if (imem_rvalid_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A redirect overrides everything. A request that memory accepts in
        // this cycle still gets a response, so the FSM must wait in DROP and
        // swallow it. A response arriving in this same cycle completes the
        // transaction, so even DROP can return to IDLE.
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ~32'h3;
            if (req_active && imem_gnt_i) begin
                state_d = S_DROP;
            end else if ((state_q == S_WAIT || state_q == S_DROP) && !imem_rvalid_i) begin
                state_d = S_DROP;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (redirect_i) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (pop)   head_d = head_q + PW'(1);
            if (wr_en) tail_d = tail_q + PW'(FETCH_WIDTH);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            started_q  <= 1'b1;
        end
    end

    // Entry storage has no reset. Entries are only observable between head
    // and tail, and the outputs are forced to zero while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                instr_mem_q[tail_idx + QUEUE_POW2'(k)] <= imem_rdata_i[32*k +: 32];
                pc_mem_q[tail_idx + QUEUE_POW2'(k)]    <= req_pc_q + 32'(4 * k);
            end
        end
    end

    assign imem_req_o  = req_active;
    assign imem_addr_o = fetch_pc_q;
    assign iq_empty_o  = empty;
    assign iq_count_o  = count;
    assign iq_instr_o  = empty ? 32'h0 : instr_mem_q[head_idx];
    assign iq_pc_o     = empty ? 32'h0 : pc_mem_q[head_idx];
    assign dbg_state_o = state_q;

endmodule
